// File: rtl/ddi_phase_scheduler_if.sv
// Handshake bundle between the DDI traffic FSM and its phase scheduler.
// The FSM side drives state and demands; the scheduler returns dwell strobe and next-phase hints.
interface ddi_phase_scheduler_if;
    logic [3:0] current_state;
    logic       east_req;
    logic       west_req;
    logic       timing_done;
    logic [1:0] phase;
    logic       sync;

    modport master (
        output current_state, east_req, west_req,
        input  timing_done, phase, sync
    );

    modport slave (
        input  current_state, east_req, west_req,
        output timing_done, phase, sync
    );
endinterface

// File: rtl/ddi_phase_scheduler.sv
// DDI dwell timer and next-phase selector; timing_done is same-cycle, phase/sync update one cycle after ALL_RED entry.
// No backpressure. Priority service is built only when DDI_PRIORITY_EN is defined.
module ddi_phase_scheduler #(
    parameter int T_RED    = 4,
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 5,
    parameter int T_PRIO   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    ddi_phase_scheduler_if.slave  bus
);
    localparam logic [3:0] S_ALL_RED   = 4'd0;
    localparam logic [3:0] S_P1_YELLOW = 4'd2;
    localparam logic [3:0] S_P2_YELLOW = 4'd4;
    localparam logic [3:0] S_EB_GREEN  = 4'd5;
    localparam logic [3:0] S_WB_GREEN  = 4'd7;
    localparam logic [3:0] S_MAINT     = 4'd9;

    logic [3:0] prev_state;
    logic       first;
    logic [7:0] cnt;
    logic [7:0] dwell;
    logic [7:0] idx;
    logic       timed;
    logic       entry;
    logic       done;
    logic [1:0] phase_q;
    logic [1:0] last_norm;
    logic       sync_q;
    logic       pend_e;
    logic       pend_w;
    logic       last_prio;

    always_comb begin
        dwell = 8'd0;
        timed = 1'b1;
        case (bus.current_state)
            4'd0:                   dwell = 8'(T_RED);
            4'd1, 4'd3:             dwell = 8'(T_GREEN);
            4'd2, 4'd4, 4'd6, 4'd8: dwell = 8'(T_YELLOW);
            4'd5, 4'd7:             dwell = 8'(T_PRIO);
            default:                timed = 1'b0;
        endcase
    end

    // entry marks dwell cycle 1; the periodic re-count after a strobe does not.
    assign entry = first || (bus.current_state != prev_state);
    assign idx   = entry ? 8'd1 : cnt + 8'd1;
    assign done  = timed && (idx == dwell);

    assign bus.timing_done = done && !rst;
    assign bus.phase       = phase_q;
    assign bus.sync        = sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first      <= 1'b1;
            prev_state <= 4'd0;
            cnt        <= 8'd0;
        end else begin
            first      <= 1'b0;
            prev_state <= bus.current_state;
            cnt        <= (!timed || done) ? 8'd0 : idx;
        end
    end

`ifdef DDI_PRIORITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_e    <= 1'b0;
            pend_w    <= 1'b0;
            last_prio <= 1'b1;
        end else begin
            if (bus.current_state == S_MAINT) begin
                pend_e <= 1'b0;
                pend_w <= 1'b0;
            end else begin
                // A new request in the clearing cycle keeps the demand pending.
                if (bus.east_req)
                    pend_e <= 1'b1;
                else if (entry && bus.current_state == S_EB_GREEN)
                    pend_e <= 1'b0;
                if (bus.west_req)
                    pend_w <= 1'b1;
                else if (entry && bus.current_state == S_WB_GREEN)
                    pend_w <= 1'b0;
            end
            if (entry && bus.current_state == S_EB_GREEN)
                last_prio <= 1'b0;
            else if (entry && bus.current_state == S_WB_GREEN)
                last_prio <= 1'b1;
        end
    end
`else
    logic unused_req;
    assign unused_req = bus.east_req ^ bus.west_req;
    assign pend_e     = 1'b0;
    assign pend_w     = 1'b0;
    assign last_prio  = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= 2'b01;
            sync_q    <= 1'b0;
            last_norm <= 2'b01;
        end else begin
            if (entry && bus.current_state == S_P1_YELLOW)
                last_norm <= 2'b00;
            else if (entry && bus.current_state == S_P2_YELLOW)
                last_norm <= 2'b01;
            if (entry && bus.current_state == S_ALL_RED) begin
                if (pend_e || pend_w) begin
                    phase_q <= 2'b10;
                    sync_q  <= (pend_e && pend_w) ? ~last_prio : pend_w;
                end else begin
                    phase_q <= last_norm;
                    sync_q  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ddi_phase_scheduler.sv
// Directed bench for ddi_phase_scheduler; expectations follow the build's DDI_PRIORITY_EN setting.
module tb_ddi_phase_scheduler;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic done_s;
    logic done1_s;
    logic [1:0] ph_s;
    logic sy_s;

    ddi_phase_scheduler_if bus ();
    ddi_phase_scheduler_if bus1 ();

    ddi_phase_scheduler dut (.clk(clk), .rst(rst), .bus(bus.slave));
    ddi_phase_scheduler #(.T_RED(1), .T_GREEN(1), .T_YELLOW(1), .T_PRIO(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    assign bus1.current_state = bus.current_state;
    assign bus1.east_req      = bus.east_req;
    assign bus1.west_req      = bus.west_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    // Called at 1 time unit after a rising edge; returns at the same point one cycle later.
    task automatic tick(input logic [3:0] st, input logic e, input logic w);
        bus.current_state = st;
        bus.east_req      = e;
        bus.west_req      = w;
        @(negedge clk);
        done_s  = bus.timing_done;
        done1_s = bus1.timing_done;
        ph_s    = bus.phase;
        sy_s    = bus.sync;
        @(posedge clk);
        #1;
    endtask

    // Closed-loop dwell: stays in st until timing_done; ecyc/wcyc <0 hold the request, >0 pulse it in that cycle.
    task automatic dwell(input logic [3:0] st, input int ecyc, input int wcyc, output int len);
        len = 0;
        for (int c = 1; c <= 300; c++) begin
            tick(st, (ecyc < 0) || (c == ecyc), (wcyc < 0) || (c == wcyc));
            if (done_s) begin
                len = c;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.current_state = 4'd0;
        bus.east_req = 1'b0;
        bus.west_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.current_state = 4'd0;
        bus.east_req = 1'b0;
        bus.west_req = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.timing_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", bus.timing_done); end
        n_vec++; if (bus.phase !== 2'b01) begin n_err++; $display("FAIL reset_phase got=%b want=01", bus.phase); end
        n_vec++; if (bus.sync !== 1'b0) begin n_err++; $display("FAIL reset_sync got=%b want=0", bus.sync); end
        n_vec++; if (bus1.timing_done !== 1'b0) begin n_err++; $display("FAIL reset_done_d1 got=%b want=0", bus1.timing_done); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_red_dwell();
        logic [7:0] mask;
        mask = 8'h00;
        for (int c = 1; c <= 8; c++) begin
            tick(4'd0, 1'b0, 1'b0);
            mask[c-1] = done_s;
        end
        n_vec++; if (mask !== 8'b1000_1000) begin n_err++; $display("FAIL red_done_pattern got=%b want=10001000", mask); end
        n_vec++; if (ph_s !== 2'b01) begin n_err++; $display("FAIL red_phase got=%b want=01", ph_s); end
    endtask

    task automatic test_normal();
        int l;
        dwell(4'd1, 0, 0, l);
        n_vec++; if (l != 20) begin n_err++; $display("FAIL p1_green_len got=%0d want=20", l); end
        dwell(4'd2, 0, 0, l);
        n_vec++; if (l != 5) begin n_err++; $display("FAIL p1_yellow_len got=%0d want=5", l); end
        dwell(4'd0, 0, 0, l);
        n_vec++; if (l != 4) begin n_err++; $display("FAIL red_after_p1_len got=%0d want=4", l); end
        n_vec++; if (ph_s !== 2'b00) begin n_err++; $display("FAIL phase_after_p1 got=%b want=00", ph_s); end
        dwell(4'd3, 0, 0, l);
        n_vec++; if (l != 20) begin n_err++; $display("FAIL p2_green_len got=%0d want=20", l); end
        dwell(4'd4, 0, 0, l);
        n_vec++; if (l != 5) begin n_err++; $display("FAIL p2_yellow_len got=%0d want=5", l); end
        dwell(4'd0, 0, 0, l);
        n_vec++; if (ph_s !== 2'b01) begin n_err++; $display("FAIL phase_after_p2 got=%b want=01", ph_s); end
    endtask

    task automatic test_east_prio();
        int l;
        logic [1:0] exp_ph;
`ifdef DDI_PRIORITY_EN
        exp_ph = 2'b10;
`else
        exp_ph = 2'b00;
`endif
        dwell(4'd1, 3, 0, l);
        dwell(4'd2, 0, 0, l);
        dwell(4'd0, 0, 0, l);
        n_vec++; if (ph_s !== exp_ph) begin n_err++; $display("FAIL east_phase got=%b want=%b", ph_s, exp_ph); end
        n_vec++; if (sy_s !== 1'b0) begin n_err++; $display("FAIL east_sync got=%b want=0", sy_s); end
        dwell(4'd5, 0, 0, l);
        n_vec++; if (l != 10) begin n_err++; $display("FAIL eb_green_len got=%0d want=10", l); end
        dwell(4'd6, 0, 0, l);
        n_vec++; if (l != 5) begin n_err++; $display("FAIL eb_yellow_len got=%0d want=5", l); end
        dwell(4'd0, 0, 0, l);
        n_vec++; if (ph_s !== 2'b00) begin n_err++; $display("FAIL phase_after_eb got=%b want=00", ph_s); end
    endtask

    task automatic test_both_alternate();
        int l;
        logic [1:0] exp_ph;
        logic exp_s1, exp_s2;
`ifdef DDI_PRIORITY_EN
        exp_ph = 2'b10; exp_s1 = 1'b1; exp_s2 = 1'b0;
`else
        exp_ph = 2'b00; exp_s1 = 1'b0; exp_s2 = 1'b0;
`endif
        do_reset();
        dwell(4'd0, -1, -1, l);
        n_vec++; if (ph_s !== 2'b01) begin n_err++; $display("FAIL both_first_red_phase got=%b want=01", ph_s); end
        dwell(4'd1, -1, -1, l);
        dwell(4'd2, -1, -1, l);
        dwell(4'd0, -1, -1, l);
        n_vec++; if (ph_s !== exp_ph) begin n_err++; $display("FAIL both_phase_1 got=%b want=%b", ph_s, exp_ph); end
        n_vec++; if (sy_s !== 1'b0) begin n_err++; $display("FAIL both_sync_1 got=%b want=0", sy_s); end
        dwell(4'd5, -1, -1, l);
        dwell(4'd6, -1, -1, l);
        dwell(4'd0, -1, -1, l);
        n_vec++; if (ph_s !== exp_ph) begin n_err++; $display("FAIL both_phase_2 got=%b want=%b", ph_s, exp_ph); end
        n_vec++; if (sy_s !== exp_s1) begin n_err++; $display("FAIL both_sync_2 got=%b want=%b", sy_s, exp_s1); end
        dwell(4'd7, -1, -1, l);
        n_vec++; if (l != 10) begin n_err++; $display("FAIL wb_green_len got=%0d want=10", l); end
        dwell(4'd8, -1, -1, l);
        dwell(4'd0, -1, -1, l);
        n_vec++; if (sy_s !== exp_s2) begin n_err++; $display("FAIL both_sync_3 got=%b want=%b", sy_s, exp_s2); end
    endtask

    task automatic test_maintenance();
        int l;
        int ndone;
        ndone = 0;
        for (int c = 0; c < 50; c++) begin
            tick(4'd9, 1'b1, 1'b0);
            if (done_s || done1_s) ndone++;
        end
        n_vec++; if (ndone != 0) begin n_err++; $display("FAIL maint_done_count got=%0d want=0", ndone); end
        dwell(4'd0, 0, 0, l);
        n_vec++; if (l != 4) begin n_err++; $display("FAIL post_maint_red_len got=%0d want=4", l); end
        n_vec++; if (ph_s !== 2'b00) begin n_err++; $display("FAIL post_maint_phase got=%b want=00", ph_s); end
    endtask

    task automatic test_reset_mid_dwell();
        int l;
        for (int c = 1; c <= 11; c++) tick(4'd3, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        n_vec++; if (bus.phase !== 2'b01) begin n_err++; $display("FAIL midrst_phase got=%b want=01", bus.phase); end
        n_vec++; if (bus.timing_done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b want=0", bus.timing_done); end
        n_vec++; if (bus.sync !== 1'b0) begin n_err++; $display("FAIL midrst_sync got=%b want=0", bus.sync); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        dwell(4'd3, 0, 0, l);
        n_vec++; if (l != 20) begin n_err++; $display("FAIL post_rst_p2_len got=%0d want=20", l); end
    endtask

    task automatic test_min_dwell();
        do_reset();
        tick(4'd0, 1'b0, 1'b0);
        n_vec++; if (done1_s !== 1'b1) begin n_err++; $display("FAIL d1_first_cycle got=%b want=1", done1_s); end
        tick(4'd0, 1'b0, 1'b0);
        n_vec++; if (done1_s !== 1'b1) begin n_err++; $display("FAIL d1_repeat got=%b want=1", done1_s); end
        tick(4'd2, 1'b0, 1'b0);
        n_vec++; if (done1_s !== 1'b1) begin n_err++; $display("FAIL d1_new_state got=%b want=1", done1_s); end
        tick(4'd12, 1'b0, 1'b0);
        n_vec++; if (done1_s !== 1'b0) begin n_err++; $display("FAIL d1_illegal_code got=%b want=0", done1_s); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_red_dwell();
        test_normal();
        test_east_prio();
        test_both_alternate();
        test_maintenance();
        test_reset_mid_dwell();
        test_min_dwell();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ddi_phase_scheduler.md
DDI_PHASE_SCHEDULER -- requirements
Module: ddi_phase_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- T_RED, 4, ALL_RED dwell in cycles
- T_GREEN, 20, PHASE_1/PHASE_2 green dwell
- T_YELLOW, 5, any yellow dwell
- T_PRIO, 10, EASTBOUND/WESTBOUND green dwell
- Legal range of each parameter is 1..255.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- current_state  in  4  DDI FSM state (0 ALL_RED, 1 P1_GREEN, 2 P1_YELLOW, 3 P2_GREEN, 4 P2_YELLOW, 5 EB_GREEN, 6 EB_YELLOW, 7 WB_GREEN, 8 WB_YELLOW, 9 MAINTENANCE)
- east_req  in  1  eastbound priority demand, sampled every cycle
- west_req  in  1  westbound priority demand, sampled every cycle
- timing_done  out  1  dwell-complete strobe to FSM
- phase  out  2  to FSM: 00 phase 1 last served, 01 phase 2 last served, 10 priority
- sync  out  1  to FSM: 0 east, 1 west; meaningful only when phase=10

Function
REQ-003 Dwell cycle 1 = first clock cycle in which current_state holds a value different from the previous cycle, or the first cycle after reset release.
REQ-004 The dwell D is selected by current_state:
- ALL_RED: T_RED
- states 1 and 3: T_GREEN
- states 2, 4, 6 and 8: T_YELLOW
- states 5 and 7: T_PRIO
REQ-005 timing_done asserts only in dwell cycle D, for one cycle; if state is unchanged afterwards it re-asserts every D cycles.
REQ-006 With D=1, timing_done asserts in dwell cycle 1.
REQ-007 In MAINTENANCE and in codes 10..15, timing_done is held 0 and the dwell count restarts.
REQ-008 pend_e sets in any cycle east_req=1; it clears in dwell cycle 1 of EB_GREEN; a set and a clear in the same cycle leave it set.
REQ-009 pend_w behaves the same with west_req and WB_GREEN.
REQ-010 phase and sync are registered and update only in dwell cycle 1 of ALL_RED; they hold otherwise.
REQ-011 Update decision:
- If any pend is set, phase=10.
- sync=0 if only pend_e is set; sync=1 if only pend_w is set.
- If both are set, sync is the opposite of last_prio, the last priority direction served.
- Otherwise phase=last_norm.
REQ-012 last_norm becomes 00 on entering P1_YELLOW and 01 on entering P2_YELLOW; it is unchanged by priority service, so normal alternation resumes where it left off.
REQ-013 last_prio becomes 0 on entering EB_GREEN and 1 on entering WB_GREEN.
REQ-014 Requests arriving after dwell cycle 1 of ALL_RED are served at the next ALL_RED.
REQ-015 On entering MAINTENANCE, pend_e and pend_w clear and requests are ignored while in MAINTENANCE; last_norm and last_prio are kept.
REQ-016 On exit from MAINTENANCE to ALL_RED, normal dwell timing restarts per REQ-003.

Reset
REQ-017 Asserting rst at any time, including mid-dwell, immediately drives:
- timing_done=0, phase=01, sync=0
- pend_e=0, pend_w=0
- last_norm=01, last_prio=1 (first tie goes east)
- dwell count cleared
REQ-018 The first cycle after rst release counts as dwell cycle 1.

Configuration
REQ-019 Macro DDI_PRIORITY_EN selects priority service.
REQ-020 With DDI_PRIORITY_EN defined, behaviour is per REQ-008..REQ-013.
REQ-021 Without DDI_PRIORITY_EN:
- east_req and west_req are ignored
- pend_e and pend_w are absent and read as 0
- phase never takes 10; sync is tied 0
- states 5..8 still use the REQ-004 dwells

Verification
REQ-022 Reset release, current_state=0, T_RED=4 -> timing_done=1 in cycle 4 only; phase=01, sync=0.
REQ-023 State sequence 0->1->2->0 with FSM closed loop -> dwells 4/20/5 cycles; at next ALL_RED, phase=00; next green is P2_GREEN.
REQ-024 east_req pulsed one cycle during P1_GREEN -> next ALL_RED gives phase=10, sync=0; pend_e clears at EB_GREEN entry; following ALL_RED gives phase=00.
REQ-025 east_req and west_req both held, with last_prio=1 -> sync=0 (east) first, then sync=1 (west) on the following priority cycle; alternation continues.
REQ-026 current_state=9 for 50 cycles with east_req=1 -> timing_done stays 0 and pend_e=0; on return to 0, timing_done fires in dwell cycle 4 and phase reflects the preserved last_norm.
REQ-027 rst asserted in dwell cycle 12 of P2_GREEN -> outputs take reset values immediately; build without DDI_PRIORITY_EN and east_req=1 -> phase never 10.
